pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed 16-bit IF/ID register; one instance sits between each pair of adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a valid bit, a halt bit, a PC and a payload of configurable width. It supports hold (write-enable low) and flush (bubble insertion). It replaces the single-bit stall-reassert flop with a multi-cycle stall counter, so the hazard unit can request 0..2^STALL_CNT_W-1 extra stall cycles in one event.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/stall_counter.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 73 +++++++
 tb/tb_pipe_stage_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and types for the pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    localparam int PC_W_DEF        = 16;
    localparam int INSTR_W_DEF     = 16;
    localparam int STALL_CNT_W_DEF = 2;

    typedef logic [STALL_CNT_W_DEF-1:0] stall_cnt_t;

endpackage

// File: rtl/stall_counter.sv
// Multi-cycle stall counter: load on request, count down to zero, clear on flush.
module stall_counter
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stallReq,
    input  logic [STALL_CNT_W-1:0] cntIn,
    output logic [STALL_CNT_W-1:0] cnt,
    output logic                   busy
);

    logic [STALL_CNT_W-1:0] cnt_r;
    logic [STALL_CNT_W-1:0] cntNext_s;

    // Next count; a fresh request overrides any residual count, and zero never wraps.
    always_comb begin
        cntNext_s = {STALL_CNT_W{1'b0}};
        if (flush) begin
            cntNext_s = {STALL_CNT_W{1'b0}};
        end else if (stallReq) begin
            cntNext_s = cntIn;
        end else if (cnt_r != {STALL_CNT_W{1'b0}}) begin
            cntNext_s = cnt_r - STALL_CNT_W'(1'b1);
        end else begin
            cntNext_s = {STALL_CNT_W{1'b0}};
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            cnt_r <= cntNext_s;
        end
    end

    assign cnt  = cnt_r;
    assign busy = (cnt_r != {STALL_CNT_W{1'b0}});

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with hold, flush and multi-cycle stall counter.
// Define PIPE_STAGE_FLUSH_ZERO_EN to make a flushed slot all-zero instead of keeping stale payload.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = INSTR_W_DEF,
    parameter int PC_W        = PC_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic                   flush,
    input  logic                   valid_in,
    input  logic                   hlt_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [PC_W-1:0]        pc_in,
    input  logic                   stall_req,
    input  logic [STALL_CNT_W-1:0] stall_cnt_in,
    output logic                   valid_out,
    output logic                   hlt_out,
    output logic [DATA_W-1:0]      data_out,
    output logic [PC_W-1:0]        pc_out,
    output logic                   stall_out,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
);

    logic              valid_r;
    logic              hlt_r;
    logic [DATA_W-1:0] data_r;
    logic [PC_W-1:0]   pc_r;

    // Stage payload: flush beats capture, capture beats hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            hlt_r   <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            pc_r    <= {PC_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
            hlt_r   <= 1'b0;
`ifdef PIPE_STAGE_FLUSH_ZERO_EN
            data_r  <= {DATA_W{1'b0}};
            pc_r    <= {PC_W{1'b0}};
`endif
        end else if (wen) begin
            valid_r <= valid_in;
            hlt_r   <= hlt_in;
            data_r  <= data_in;
            pc_r    <= pc_in;
        end
    end

    // The counter ignores wen so a held stage can still take a stall request.
    stall_counter #(
        .STALL_CNT_W (STALL_CNT_W)
    ) uStallCounter (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stallReq (stall_req),
        .cntIn    (stall_cnt_in),
        .cnt      (stall_cnt_out),
        .busy     (stall_out)
    );

    assign valid_out = valid_r;
    assign hlt_out   = hlt_r;
    assign data_out  = data_r;
    assign pc_out    = pc_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default 16-bit instance and a 32-bit/3-bit-counter instance.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic        flush;
    logic        valid_in;
    logic        hlt_in;
    logic        stall_req;
    logic [15:0] dataN;
    logic [31:0] dataW;
    logic [15:0] pcIn;
    stall_cnt_t  cntN;
    logic [2:0]  cntW;

    logic        vN, hN, sN, vW, hW, sW;
    logic [15:0] dN, pN, pW;
    logic [31:0] dW;
    logic [1:0]  cN;
    logic [2:0]  cW;

    typedef struct {
        logic        v;
        logic        h;
        logic [31:0] d;
        logic [15:0] p;
        logic        s;
        logic [2:0]  c;
    } exp_t;

    exp_t qN[$];
    exp_t qW[$];
    exp_t mN;
    exp_t mW;
    int   checks   = 0;
    int   failures = 0;
    int   stallCycles;

    always #5 clk = ~clk;

    pipe_stage_reg uDutN (
        .clk (clk), .rst (rst), .wen (wen), .flush (flush),
        .valid_in (valid_in), .hlt_in (hlt_in), .data_in (dataN), .pc_in (pcIn),
        .stall_req (stall_req), .stall_cnt_in (cntN),
        .valid_out (vN), .hlt_out (hN), .data_out (dN), .pc_out (pN),
        .stall_out (sN), .stall_cnt_out (cN)
    );

    pipe_stage_reg #(.DATA_W(32), .PC_W(16), .STALL_CNT_W(3)) uDutW (
        .clk (clk), .rst (rst), .wen (wen), .flush (flush),
        .valid_in (valid_in), .hlt_in (hlt_in), .data_in (dataW), .pc_in (pcIn),
        .stall_req (stall_req), .stall_cnt_in (cntW),
        .valid_out (vW), .hlt_out (hW), .data_out (dW), .pc_out (pW),
        .stall_out (sW), .stall_cnt_out (cW)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t zeroState();
        exp_t z;
        z.v = 1'b0; z.h = 1'b0; z.d = 32'h0; z.p = 16'h0; z.s = 1'b0; z.c = 3'd0;
        return z;
    endfunction

    // Expected state after the coming edge, from the current inputs.
    function automatic exp_t advance(input exp_t m, input logic [31:0] d, input logic [2:0] c);
        exp_t n = m;
        if (flush) begin
            n.v = 1'b0;
            n.h = 1'b0;
`ifdef PIPE_STAGE_FLUSH_ZERO_EN
            n.d = 32'h0;
            n.p = 16'h0;
`endif
        end else if (wen) begin
            n.v = valid_in;
            n.h = hlt_in;
            n.d = d;
            n.p = pcIn;
        end
        if (flush)            n.c = 3'd0;
        else if (stall_req)   n.c = c;
        else if (m.c != 3'd0) n.c = m.c - 3'd1;
        else                  n.c = 3'd0;
        n.s = (n.c != 3'd0);
        return n;
    endfunction

    task automatic compareOut();
        exp_t eN;
        exp_t eW;
        eN = qN.pop_front();
        eW = qW.pop_front();
        checkEq("validN", {31'h0, vN}, {31'h0, eN.v});
        checkEq("hltN",   {31'h0, hN}, {31'h0, eN.h});
        checkEq("dataN",  {16'h0, dN}, eN.d);
        checkEq("pcN",    {16'h0, pN}, {16'h0, eN.p});
        checkEq("stallN", {31'h0, sN}, {31'h0, eN.s});
        checkEq("cntN",   {30'h0, cN}, {29'h0, eN.c});
        checkEq("validW", {31'h0, vW}, {31'h0, eW.v});
        checkEq("hltW",   {31'h0, hW}, {31'h0, eW.h});
        checkEq("dataW",  dW, eW.d);
        checkEq("pcW",    {16'h0, pW}, {16'h0, eW.p});
        checkEq("stallW", {31'h0, sW}, {31'h0, eW.s});
        checkEq("cntW",   {29'h0, cW}, {29'h0, eW.c});
    endtask

    task automatic step(input logic f, input logic w, input logic vi, input logic hi,
                        input logic [31:0] d, input logic [15:0] p,
                        input logic sr, input logic [2:0] c);
        flush = f; wen = w; valid_in = vi; hlt_in = hi;
        dataN = d[15:0]; dataW = d; pcIn = p; stall_req = sr;
        cntN = c[1:0]; cntW = c;
        mN = advance(mN, {16'h0, d[15:0]}, {1'b0, c[1:0]});
        qN.push_back(mN);
        mW = advance(mW, d, c);
        qW.push_back(mW);
        @(posedge clk);
        #1;
        compareOut();
    endtask

    task automatic idle(input logic w);
        step(1'b0, w, 1'b1, 1'b0, $urandom, 16'($urandom), 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; flush = 1'b0; valid_in = 1'b0; hlt_in = 1'b0;
        stall_req = 1'b0; dataN = 16'h0; dataW = 32'h0; pcIn = 16'h0; cntN = 2'd0; cntW = 3'd0;
        mN = zeroState();
        mW = zeroState();

        // Reset state
        @(posedge clk); #1;
        checkEq("rstValid", {31'h0, vN}, 32'h0);
        checkEq("rstData",  {16'h0, dN}, 32'h0);
        checkEq("rstStall", {31'h0, sN}, 32'h0);
        rst = 1'b1;

        // Asynchronous reset mid-stall clears outputs before any edge
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000BEEF, 16'h0042, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BEEF, 16'h0042, 1'b1, 3'd3);
        #3;
        rst = 1'b0;
        #1;
        checkEq("arstData",  {16'h0, dN}, 32'h0);
        checkEq("arstPc",    {16'h0, pN}, 32'h0);
        checkEq("arstValid", {31'h0, vN}, 32'h0);
        checkEq("arstHlt",   {31'h0, hN}, 32'h0);
        checkEq("arstStall", {31'h0, sN}, 32'h0);
        checkEq("arstCnt",   {30'h0, cN}, 32'h0);
        checkEq("arstDataW", dW, 32'h0);
        mN = zeroState();
        mW = zeroState();
        @(posedge clk); #1;
        rst = 1'b1;

        // Capture then hold for three cycles with changing inputs
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000A123, 16'h0010, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 16'($urandom), 1'b0, 3'd0);
        checkEq("holdData", {16'h0, dN}, 32'h0000A123);
        checkEq("holdPc",   {16'h0, pN}, 32'h00000010);

        // Multi-stall of 3, with capture and then with hold
        for (int pass = 0; pass < 2; pass++) begin
            stallCycles = 0;
            step(1'b0, (pass == 0), 1'b1, 1'b0, 32'h00001111, 16'h0011, 1'b1, 3'd3);
            if (sN) stallCycles++;
            for (int i = 0; i < 4; i++) begin
                idle(pass == 0);
                if (sN) stallCycles++;
            end
            checkEq("stallLenN", stallCycles, 32'd3);
        end

        // Override: 3, then 1 after one cycle; then load 0 cancels
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h00002222, 16'h0020, 1'b1, 3'd3);
        idle(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h00003333, 16'h0021, 1'b1, 3'd1);
        idle(1'b1);
        checkEq("overrideDone", {31'h0, sN}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h00004444, 16'h0022, 1'b1, 3'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h00004444, 16'h0022, 1'b1, 3'd0);
        checkEq("loadZero", {31'h0, sN}, 32'h0);

        // Flush beats wen and stall_req
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h00005A5A, 16'h0055, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF1234, 16'h0077, 1'b1, 3'd3);
`ifdef PIPE_STAGE_FLUSH_ZERO_EN
        checkEq("flushData", {16'h0, dN}, 32'h0);
`else
        checkEq("flushData", {16'h0, dN}, 32'h00005A5A);
`endif
        checkEq("flushValid", {31'h0, vN}, 32'h0);
        checkEq("flushCnt",   {30'h0, cN}, 32'h0);

        // Wide instance: count 7 and 32-bit payload
        stallCycles = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 16'h0100, 1'b1, 3'd7);
        checkEq("wideData", dW, 32'hDEADBEEF);
        if (sW) stallCycles++;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 3'd0);
            if (sW) stallCycles++;
        end
        checkEq("stallLenW", stallCycles, 32'd7);

        // Random traffic through the scoreboard
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, 16'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
